// File: rtl/tdc_frame_packer.sv
// tdc_frame_packer
//   Buffers 32-bit TDC results {calib_diff, time1} in a small synchronous FIFO
//   and serializes each word into a byte frame for the UART transmitter:
//   SYNC_BYTE, [seq], time1 MSB-first, calib_diff MSB-first, XOR checksum.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   wr_en         word-valid level from the controller, held until writing_done
//   data_in       {calib_diff[15:0], time1[15:0]}
//   writing_done  one-cycle accept pulse, the cycle after the word is written
//   tx_data       byte to the UART, held between strobes
//   tx_new_data   one-cycle strobe, tx_data valid
//   tx_busy       UART transmitting (rises the cycle after tx_new_data)
//   fifo_count    words buffered (0 .. 2^ADDR_W)
//   fifo_full     fifo_count == 2^ADDR_W
//
// Build option
//   SEQ_BYTE_EN   when defined, an 8-bit frame sequence number follows the
//                 sync byte and is folded into the checksum (7-byte frames).

module tdc_frame_packer #(
    parameter int unsigned ADDR_W    = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [31:0]       data_in,
    output logic              writing_done,
    output logic [7:0]        tx_data,
    output logic              tx_new_data,
    input  logic              tx_busy,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_full
);

    localparam int unsigned     DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
`ifdef SEQ_BYTE_EN
        SEQ,
`endif
        D0,
        D1,
        D2,
        D3,
        CSUM
    } state_t;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              accepted;
    logic              push;
    logic              pop;

    state_t            state;
    state_t            state_next;
    state_t            after;
    logic [31:0]       w;
    logic [7:0]        csum;
    logic [7:0]        tx_byte;
    logic [7:0]        tx_data_q;
    logic              strobe_q;
    logic              can_send;
    logic              fold_csum;
`ifdef SEQ_BYTE_EN
    logic [7:0]        seq;
`endif

    // ---------------- accept side ----------------
    assign fifo_full = (fifo_count == FULL_COUNT);
    // A full FIFO stalls the word: wr_en stays high and the accept fires
    // as soon as a slot frees.
    assign push = wr_en && !accepted && !fifo_full && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            accepted     <= 1'b0;
            writing_done <= 1'b0;
        end else begin
            writing_done <= push;
            if (!wr_en)
                accepted <= 1'b0;
            else if (push)
                accepted <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    // ---------------- serializer ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // The strobe is decoded combinationally from the current state so the
    // sync byte leaves two cycles after accept. strobe_q masks the cycle
    // before the UART's busy flag has had a chance to rise.
    always_comb begin
        state_next  = state;
        after       = IDLE;
        tx_byte     = '0;
        fold_csum   = 1'b0;
        pop         = 1'b0;
        tx_new_data = 1'b0;
        can_send    = !tx_busy && !strobe_q && !rst;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    state_next = SYNC;
                end
            end
            SYNC: begin
                tx_byte = SYNC_BYTE;
`ifdef SEQ_BYTE_EN
                after   = SEQ;
`else
                after   = D0;
`endif
            end
`ifdef SEQ_BYTE_EN
            SEQ: begin
                tx_byte   = seq;
                fold_csum = 1'b1;
                after     = D0;
            end
`endif
            D0: begin
                tx_byte   = w[15:8];
                fold_csum = 1'b1;
                after     = D1;
            end
            D1: begin
                tx_byte   = w[7:0];
                fold_csum = 1'b1;
                after     = D2;
            end
            D2: begin
                tx_byte   = w[31:24];
                fold_csum = 1'b1;
                after     = D3;
            end
            D3: begin
                tx_byte   = w[23:16];
                fold_csum = 1'b1;
                after     = CSUM;
            end
            CSUM: begin
                tx_byte = csum;
                after   = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (state != IDLE && can_send) begin
            tx_new_data = 1'b1;
            state_next  = after;
        end
    end

    assign tx_data = tx_new_data ? tx_byte : tx_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            w         <= '0;
            csum      <= '0;
            tx_data_q <= '0;
            strobe_q  <= 1'b0;
`ifdef SEQ_BYTE_EN
            seq       <= '0;
`endif
        end else begin
            strobe_q <= tx_new_data;
            if (pop) begin
                w    <= mem[rd_ptr];
                csum <= '0;
            end
            if (tx_new_data) begin
                tx_data_q <= tx_byte;
                if (fold_csum)
                    csum <= csum ^ tx_byte;
            end
`ifdef SEQ_BYTE_EN
            if (tx_new_data && state == CSUM)
                seq <= seq + 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_tdc_frame_packer.sv
module tb_tdc_frame_packer;

    localparam int unsigned ADDR_W = 4;
`ifdef SEQ_BYTE_EN
    localparam int unsigned FRAME_LEN = 7;
`else
    localparam int unsigned FRAME_LEN = 6;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [31:0]       data_in = '0;
    logic              tx_busy = 1'b0;
    logic              writing_done;
    logic [7:0]        tx_data;
    logic              tx_new_data;
    logic [ADDR_W:0]   fifo_count;
    logic              fifo_full;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0]  rx_q  [$];
    logic [7:0]  exp_q [$];
    int unsigned st_q  [$];
    int unsigned cycle = 0;
    int unsigned busy_len = 0;
    bit          force_busy = 1'b0;
    logic [7:0]  model_seq = '0;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  csum;
        int unsigned busy;
    } vec_t;

    tdc_frame_packer #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .writing_done (writing_done),
        .tx_data      (tx_data),
        .tx_new_data  (tx_new_data),
        .tx_busy      (tx_busy),
        .fifo_count   (fifo_count),
        .fifo_full    (fifo_full)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: sync, [seq], time1 hi/lo, calib_diff hi/lo, XOR of the rest.
    function automatic void add_frame(input logic [31:0] wd);
        logic [15:0] time1 = wd[15:0];
        logic [15:0] calib = wd[31:16];
        logic [7:0]  body [$];
        logic [7:0]  cs = '0;
`ifdef SEQ_BYTE_EN
        body.push_back(model_seq);
        model_seq = model_seq + 8'd1;
`endif
        body.push_back(time1[15:8]);
        body.push_back(time1[7:0]);
        body.push_back(calib[15:8]);
        body.push_back(calib[7:0]);
        exp_q.push_back(8'hA5);
        foreach (body[i]) begin
            exp_q.push_back(body[i]);
            cs = cs ^ body[i];
        end
        exp_q.push_back(cs);
    endfunction

    // UART stand-in: records strobes, then holds busy for busy_len cycles
    // starting the cycle after each strobe.
    initial begin : uart_model
        bit          seen;
        logic        prev = 1'b0;
        int unsigned left = 0;
        forever begin
            @(negedge clk);
            cycle++;
            seen = tx_new_data;
            if (seen) begin
                chk("strobe_while_busy", tx_busy, 0);
                chk("back_to_back_strobe", prev, 0);
                rx_q.push_back(tx_data);
                st_q.push_back(cycle);
            end
            prev = seen;
            @(posedge clk);
            #1;
            if (seen)
                left = busy_len;
            else if (left > 0)
                left--;
            tx_busy = force_busy || (left > 0);
        end
    end

    task automatic push_word(input logic [31:0] d, input int unsigned limit);
        int unsigned n = 0;
        bit          got = 1'b0;
        @(posedge clk);
        #1;
        wr_en   = 1'b1;
        data_in = d;
        while (!got && n < limit) begin
            @(negedge clk);
            if (writing_done) got = 1'b1;
            else n++;
        end
        chk("accept", got, 1);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (got) add_frame(d);
    endtask

    task automatic wait_rx(input int unsigned limit);
        int unsigned n = 0;
        while (rx_q.size() < exp_q.size() && n < limit) begin
            @(posedge clk);
            n++;
        end
        repeat (20) @(posedge clk);
        chk("rx_byte_count", rx_q.size(), exp_q.size());
    endtask

    task automatic compare_rx(input string tag);
        int unsigned m = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int unsigned i = 0; i < m; i++)
            chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin : main
        vec_t        vt [7];
        logic        done_v [6];
        logic        str_v  [6];
        logic [4:0]  cnt_v  [6];
        logic [7:0]  dat_v  [6];
        int unsigned tail;
        int unsigned done_cnt;
        int unsigned max_cnt;
        int unsigned n;
        bit          got;
        logic [7:0]  s;

        vt[0] = '{32'h1234_ABCD, 8'h40, 0};
        vt[1] = '{32'h0000_0000, 8'h00, 1};
        vt[2] = '{32'hFFFF_FFFF, 8'h00, 2};
        vt[3] = '{32'hA5A5_A5A5, 8'h00, 0};
        vt[4] = '{32'h0001_0000, 8'h01, 3};
        vt[5] = '{32'hDEAD_BEEF, 8'h22, 1};
        vt[6] = '{32'h8000_0001, 8'h81, 5};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_writing_done", writing_done, 0);
        chk("rst_tx_new_data", tx_new_data, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_fifo_full", fifo_full, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single word, cycle-accurate handshake and latency
        busy_len = 0;
        repeat (3) @(posedge clk);
        #1;
        wr_en   = 1'b1;
        data_in = 32'h1234_ABCD;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            done_v[i] = writing_done;
            cnt_v[i]  = fifo_count;
            str_v[i]  = tx_new_data;
            dat_v[i]  = tx_data;
            if (i == 4) begin
                @(posedge clk);
                #1;
                wr_en = 1'b0;
            end
        end
        tail = 0;
        for (int i = 2; i < 6; i++) tail += done_v[i];
        chk("done_not_in_accept_cycle", done_v[0], 0);
        chk("done_next_cycle", done_v[1], 1);
        chk("done_once", tail, 0);
        chk("count_after_accept", cnt_v[1], 1);
        chk("count_after_pop", cnt_v[2], 0);
        chk("no_early_strobe", str_v[1], 0);
        chk("sync_latency", str_v[2], 1);
        chk("sync_byte", dat_v[2], 8'hA5);
        chk("strobe_gap", str_v[3], 0);
        chk("d0_byte", dat_v[4], 8'hAB);
        add_frame(32'h1234_ABCD);
        wait_rx(200);
        chk("single_csum", rx_q[FRAME_LEN-1], 8'h40);
        compare_rx("single");
        chk("single_count_end", fifo_count, 0);

        // wr_en held high long after writing_done
        @(posedge clk);
        #1;
        wr_en   = 1'b1;
        data_in = 32'hCAFE_F00D;
        done_cnt = 0;
        max_cnt  = 0;
        repeat (24) begin
            @(negedge clk);
            done_cnt += writing_done;
            if (fifo_count > max_cnt) max_cnt = fifo_count;
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        chk("hold_done_count", done_cnt, 1);
        chk("hold_max_count", max_cnt, 1);
        add_frame(32'hCAFE_F00D);
        wait_rx(200);
        compare_rx("hold");

        // vector table
        for (int i = 0; i < 7; i++) begin
            busy_len = vt[i].busy;
            s = model_seq;
            push_word(vt[i].data, 50);
            wait_rx(500);
            chk($sformatf("tbl%0d_csum", i), rx_q[FRAME_LEN-1], vt[i].csum ^ s);
            compare_rx($sformatf("tbl%0d", i));
        end

        // fill under forced busy, then a stalled word
        busy_len   = 0;
        force_busy = 1'b1;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 17; i++)
            push_word(32'h1000_0000 + 32'(i) * 32'h0101_0101, 50);
        @(negedge clk);
        chk("fill_full", fifo_full, 1);
        chk("fill_count", fifo_count, 16);
        @(posedge clk);
        #1;
        wr_en   = 1'b1;
        data_in = 32'h5A5A_0017;
        done_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            done_cnt += writing_done;
        end
        chk("stall_no_done", done_cnt, 0);
        chk("stall_count", fifo_count, 16);
        force_busy = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            if (writing_done) got = 1'b1;
            else n++;
        end
        chk("stall_accept", got, 1);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (got) add_frame(32'h5A5A_0017);
        wait_rx(3000);
        compare_rx("fill");

        // long UART backpressure
        busy_len = 100;
        st_q.delete();
        push_word(32'h0102_0304, 50);
        push_word(32'hF0E1_D2C3, 50);
        wait_rx(3000);
        for (int unsigned i = 1; i < st_q.size(); i++)
            chk($sformatf("bp_gap%0d", i), st_q[i] - st_q[i-1], 101);
        compare_rx("bp");
        busy_len = 0;
        repeat (110) @(posedge clk);

        // reset between D1 and D2 with three words queued
        busy_len   = 1;
        force_busy = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 4; i++)
            push_word(32'h7700_0000 + 32'(i), 50);
        chk("rstmid_queued", fifo_count, 3);
        @(posedge clk);
        #1;
        force_busy = 1'b0;
        n = 0;
        while (rx_q.size() < 3 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        rst = 1'b1;
        chk("rstmid_bytes_before", rx_q.size(), 3);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_writing_done", writing_done, 0);
        chk("rstmid_tx_new_data", tx_new_data, 0);
        chk("rstmid_tx_data", tx_data, 8'h00);
        chk("rstmid_fifo_count", fifo_count, 0);
        chk("rstmid_fifo_full", fifo_full, 0);
        repeat (30) @(negedge clk);
        chk("rstmid_no_more_strobes", rx_q.size(), 3);
        chk("rstmid_count_idle", fifo_count, 0);
        rx_q.delete();
        exp_q.delete();
        model_seq = '0;
        push_word(32'h0BAD_F00D, 50);
        wait_rx(200);
        compare_rx("post_rst");

        // randomized traffic against the reference frame model
        for (int i = 0; i < 30; i++) begin
            busy_len = $urandom_range(0, 3);
            repeat ($urandom_range(0, 4)) @(posedge clk);
            push_word($urandom, 200);
        end
        wait_rx(5000);
        compare_rx("rand");

`ifdef SEQ_BYTE_EN
        // sequence number wrap over 257 frames
        busy_len = 0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_seq = '0;
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 257; i++)
            push_word($urandom, 200);
        wait_rx(20000);
        for (int unsigned f = 0; f < 257; f++)
            chk($sformatf("seq_frame%0d", f), rx_q[f*7+1], 8'(f));
        compare_rx("seq");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
